// File: rtl/arm_const.sv
// arm_const: shared constants and types for the ARM core's memory-mapped data path.
package arm_const;
    localparam int VGA_SCREEN_SIZE = 64;
    localparam logic [13:0] IO_CTRL      = 14'h0000;
    localparam logic [13:0] IO_FRAME_CNT = 14'h0004;
    typedef enum logic [1:0] {REG_RAM, REG_VRAM, REG_IO, REG_NONE} dmem_region_t;
    typedef enum logic {SWAP_IDLE, SWAP_PENDING} swap_state_t;
endpackage

// File: rtl/vram_dbuf.sv
// vram_dbuf: two VRAM banks; the CPU reads and writes the back bank while tex_o shows the front bank.
module vram_dbuf #(
    parameter int DATA_W     = 32,
    parameter int VRAM_WORDS = arm_const::VGA_SCREEN_SIZE,
    localparam int LANES     = DATA_W / 8,
    localparam int IW        = $clog2(VRAM_WORDS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              toggle_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IW-1:0]     idx_i,
    input  logic [LANES-1:0]  wmask_i,
    input  logic [DATA_W-1:0] wd_i,
    output logic [DATA_W-1:0] rd_o,
    output logic              front_o,
    output logic [DATA_W-1:0] tex_o [VRAM_WORDS]
);
    logic [DATA_W-1:0] bank_q [2][VRAM_WORDS];
    logic [DATA_W-1:0] rd_q;
    logic              front_q;
    always_ff @(posedge clk) begin
        if (!reset_n) front_q <= 1'b0;
        else if (toggle_i) front_q <= !front_q;
    end
    // Both ports use the pre-toggle back bank, so a write on the swap edge lands in the new front bank.
    always_ff @(posedge clk) begin
        if (re_i) rd_q <= bank_q[!front_q][idx_i];
        for (int l = 0; l < LANES; l++)
            if (we_i && wmask_i[l]) bank_q[!front_q][idx_i][8*l +: 8] <= wd_i[8*l +: 8];
    end
    always_comb
        for (int i = 0; i < VRAM_WORDS; i++) tex_o[i] = bank_q[front_q][i];
    assign rd_o    = rd_q;
    assign front_o = front_q;
endmodule

// File: rtl/dmem_mapped.sv
// dmem_mapped: decoded data-memory map (byte-lane RAM, double-buffered VRAM, IO page) with
// a vsync-synchronised VRAM bank swap.
module dmem_mapped
    import arm_const::*;
#(
    parameter int DATA_W     = 32,
    parameter int RAM_WORDS  = 4096,
    parameter int VRAM_WORDS = VGA_SCREEN_SIZE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic              re,
    input  logic              size,
    input  logic [31:0]       a,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd,
    output logic              rvalid,
    output logic              err,
    input  logic              vsync,
    output logic              swap_pending,
    output logic [DATA_W-1:0] tex_o [VRAM_WORDS]
);
    localparam int LANES = DATA_W / 8;
    localparam int RW    = $clog2(RAM_WORDS);
    localparam int VW    = $clog2(VRAM_WORDS);
    dmem_region_t      region, src_q;
    swap_state_t       state_q, state_d;
    logic [11:0]       idx;
    logic [13:0]       off;
    logic [1:0]        lane, lane_q;
    logic              bad, ok_w, ram_we, vram_we, vram_re, ctrl_req, toggle, front;
    logic              rvalid_q, err_q, byte_q, unused_hi;
    logic [LANES-1:0]  wmask;
    logic [DATA_W-1:0] wdata, io_rd, vram_rd, raw, rd_q;
    logic [31:0]       frame_q;
    logic [DATA_W-1:0] ram_q [RAM_WORDS];
    assign region    = dmem_region_t'(a[15:14]);
    assign off       = a[13:0];
    assign idx       = a[13:2];
    assign lane      = a[1:0];
    assign unused_hi = ^a[31:16];
    always_comb begin
        bad = (!size && lane != 2'd0) ||
              (region == REG_RAM  ? int'(idx) >= RAM_WORDS :
               region == REG_VRAM ? int'(idx) >= VRAM_WORDS :
               region == REG_IO   ? size || (off != IO_CTRL && off != IO_FRAME_CNT) : 1'b1);
        wmask    = size ? LANES'(1) << lane : '1;
        wdata    = size ? {LANES{wd[7:0]}} : wd;
        ok_w     = we && !bad;
        ram_we   = ok_w && region == REG_RAM;
        vram_we  = ok_w && region == REG_VRAM;
        vram_re  = re && !bad && region == REG_VRAM;
        ctrl_req = ok_w && region == REG_IO && off == IO_CTRL && wd[0];
        io_rd    = off == IO_FRAME_CNT ? DATA_W'(frame_q) : DATA_W'({front, swap_pending});
        state_d  = state_q == SWAP_IDLE ? (ctrl_req ? SWAP_PENDING : SWAP_IDLE)
                                        : (vsync ? SWAP_IDLE : SWAP_PENDING);
        toggle   = state_q == SWAP_PENDING && vsync;
    end
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++)
            if (ram_we && wmask[l]) ram_q[idx[RW-1:0]][8*l +: 8] <= wdata[8*l +: 8];
    end
    // VRAM data arrives registered from vram_dbuf, so only its source tag is held here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= SWAP_IDLE;
            frame_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= '0;
            src_q    <= REG_NONE;
            byte_q   <= 1'b0;
            lane_q   <= '0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_q + 32'(vsync);
            rvalid_q <= re;
            err_q    <= (we || re) && bad;
            if (re) begin
                src_q  <= bad ? REG_NONE : region;
                rd_q   <= bad ? '0 : region == REG_RAM ? ram_q[idx[RW-1:0]] : region == REG_IO ? io_rd : '0;
                byte_q <= size;
                lane_q <= lane;
            end
        end
    end
    vram_dbuf #(.DATA_W(DATA_W), .VRAM_WORDS(VRAM_WORDS)) u_vram (
        .clk     (clk),
        .reset_n (reset_n),
        .toggle_i(toggle),
        .we_i    (vram_we),
        .re_i    (vram_re),
        .idx_i   (idx[VW-1:0]),
        .wmask_i (wmask),
        .wd_i    (wdata),
        .rd_o    (vram_rd),
        .front_o (front),
        .tex_o   (tex_o)
    );
    assign raw          = src_q == REG_VRAM ? vram_rd : rd_q;
    assign rd           = byte_q ? DATA_W'(raw[8*lane_q +: 8]) : raw;
    assign rvalid       = rvalid_q;
    assign err          = err_q;
    assign swap_pending = state_q == SWAP_PENDING;
endmodule

// File: tb/tb_dmem_mapped.sv
// tb_dmem_mapped: random and directed accesses scored against a byte-addressed reference model.
module tb_dmem_mapped;
    localparam int VW        = arm_const::VGA_SCREEN_SIZE;
    localparam int RAM_WORDS = 4096;
    typedef struct {
        int          cyc;
        logic        rvalid;
        logic        err;
        logic        pend;
        logic [31:0] rd;
    } exp_t;
    logic        clk = 0, reset_n = 0, we = 0, re = 0, size = 0, vsync = 0;
    logic [31:0] a = 0, wd = 0, rd;
    logic        rvalid, err, swap_pending;
    logic [31:0] tex [VW];
    int          cyc = 0, n_assert = 0, n_fail = 0;
    exp_t        q[$];
    exp_t        me;
    logic [7:0]  ram_m [RAM_WORDS*4];
    logic [7:0]  vram_m [2][VW*4];
    logic        front_m = 0, pend_m = 0, s;
    logic [31:0] frame_m = 0, last_rd_m = 0, ad;

    dmem_mapped #(.DATA_W(32), .RAM_WORDS(RAM_WORDS), .VRAM_WORDS(VW)) dut (
        .clk(clk), .reset_n(reset_n), .we(we), .re(re), .size(size), .a(a), .wd(wd),
        .rd(rd), .rvalid(rvalid), .err(err), .vsync(vsync), .swap_pending(swap_pending),
        .tex_o(tex)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rbyte(input int rg, input int b);
        return rg == 0 ? ram_m[b] : vram_m[!front_m][b];
    endfunction

    task automatic wbyte(input int rg, input int b, input logic [7:0] v);
        if (rg == 0) ram_m[b] = v;
        else vram_m[!front_m][b] = v;
    endtask

    // Reference: state after the clock edge that consumes these inputs.
    task automatic model_step(input logic w, r, sz, input logic [31:0] addr, data, input logic vs,
                              output exp_t e);
        int rg, off, idx;
        bit bad, req;
        logic [31:0] rv;
        rg  = int'(addr[15:14]);
        off = int'(addr[13:0]);
        idx = off / 4;
        req = 0;
        rv  = 0;
        bad = (!sz && off % 4 != 0) || rg == 3 || (rg == 0 && idx >= RAM_WORDS) ||
              (rg == 1 && idx >= VW) || (rg == 2 && (sz || (off != 0 && off != 4)));
        if (!bad && rg < 2)
            rv = sz ? {24'h0, rbyte(rg, off)}
                    : {rbyte(rg, off + 3), rbyte(rg, off + 2), rbyte(rg, off + 1), rbyte(rg, off)};
        else if (!bad) rv = off == 4 ? frame_m : {30'h0, front_m, pend_m};
        if (r) last_rd_m = bad ? 32'h0 : rv;
        if (w && !bad) begin
            if (rg < 2 && sz) wbyte(rg, off, data[7:0]);
            else if (rg < 2) for (int k = 0; k < 4; k++) wbyte(rg, off + k, data[8*k +: 8]);
            else if (off == 0 && data[0]) req = 1;
        end
        if (pend_m && vs) begin
            front_m = !front_m;
            pend_m  = 0;
        end else if (!pend_m && req) pend_m = 1;
        if (vs) frame_m++;
        e = '{cyc, r, (w || r) && bad, pend_m, last_rd_m};
    endtask

    task automatic op(input logic w, r, sz, input logic [31:0] addr, data, input logic vs);
        exp_t e;
        we = w; re = r; size = sz; a = addr; wd = data; vsync = vs;
        model_step(w, r, sz, addr, data, vs, e);
        q.push_back(e);
        @(negedge clk);
        we = 0; re = 0; vsync = 0;
    endtask

    task automatic check_tex();
        int nbad, first;
        logic [31:0] ex, got, fex;
        nbad = 0; first = -1; got = 0; fex = 0;
        for (int i = 0; i < VW; i++) begin
            ex = {vram_m[front_m][4*i+3], vram_m[front_m][4*i+2], vram_m[front_m][4*i+1], vram_m[front_m][4*i]};
            if (tex[i] !== ex) begin
                nbad++;
                if (first < 0) begin first = i; got = tex[i]; fex = ex; end
            end
        end
        n_assert++;
        if (nbad != 0) begin
            n_fail++;
            $display("FAIL tex_o: %0d words differ, first tex_o[%0d] got %h expected %h", nbad, first, got, fex);
        end
    endtask

    always @(negedge clk)
        if (q.size() > 0 && q[0].cyc < cyc) begin
            me = q.pop_front();
            chk("rvalid", 32'(rvalid), 32'(me.rvalid));
            chk("err", 32'(err), 32'(me.err));
            chk("swap_pending", 32'(swap_pending), 32'(me.pend));
            chk("rd", rd, me.rd);
        end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset rvalid", 32'(rvalid), 0);
        chk("reset err", 32'(err), 0);
        chk("reset swap_pending", 32'(swap_pending), 0);
        chk("reset rd", rd, 0);
        reset_n = 1;
        for (int i = 0; i < VW; i++) op(1, 0, 0, 32'h4000 + 4*i, $urandom, 0);
        op(1, 0, 0, 32'h8000, 1, 0);
        op(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < VW; i++) op(1, 0, 0, 32'h4000 + 4*i, $urandom, 0);
        for (int i = 0; i < 16; i++) op(1, 0, 0, 4*i, $urandom, 0);
        check_tex();
        op(1, 0, 0, 32'h10, 32'hDEADBEEF, 0);
        op(0, 1, 0, 32'h10, 0, 0);
        op(0, 1, 1, 32'h11, 0, 0);
        op(1, 0, 1, 32'h12, 32'h55, 0);
        op(0, 1, 0, 32'h10, 0, 0);
        op(1, 0, 0, 32'h13, 32'hFFFFFFFF, 0);
        op(0, 1, 0, 32'h10, 0, 0);
        op(1, 0, 0, 32'h4000, 32'h12345678, 0);
        op(0, 1, 0, 32'h4000, 0, 0);
        check_tex();
        op(1, 0, 0, 32'h8000, 1, 0);
        op(0, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 0, 1);
        check_tex();
        op(0, 1, 0, 32'h8000, 0, 0);
        op(1, 0, 0, 32'h8000, 1, 1);
        op(0, 1, 0, 32'h8000, 0, 0);
        op(0, 0, 0, 0, 0, 1);
        check_tex();
        op(1, 1, 0, 32'h8004, 32'hFFFF, 0);
        op(0, 1, 0, 32'hC000, 0, 0);
        op(1, 0, 0, 32'hC000, 32'hA5A5A5A5, 0);
        op(0, 1, 0, 32'h4000 + 4*VW, 0, 0);
        op(1, 0, 0, 32'h4000 + 4*VW, 32'h5A5A5A5A, 0);
        op(0, 1, 1, 32'h8000, 0, 0);
        op(1, 1, 0, 32'h4004, 32'hCAFEF00D, 0);
        op(0, 1, 0, 32'h4004, 0, 0);
        check_tex();
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: ad = $urandom_range(0, 63);
                3, 4, 5: ad = 32'h4000 + $urandom_range(0, 4*VW - 1);
                6:       ad = 32'h8000 + 4 * $urandom_range(0, 1);
                7:       ad = 32'h8000 + $urandom_range(0, 15);
                8:       ad = 32'hC000 + $urandom_range(0, 255);
                default: ad = 32'h4000 + 4*VW + $urandom_range(0, 63);
            endcase
            s = $urandom_range(0, 3) == 0;
            if (!s && $urandom_range(0, 7) != 0) ad[1:0] = 2'b00;
            ad[31:16] = 16'($urandom);
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s, ad, $urandom,
               $urandom_range(0, 7) == 0);
            if (n % 100 == 99) check_tex();
        end
        op(1, 0, 0, 32'h8000, 1, 0);
        reset_n = 0; re = 1; size = 0; a = 32'h10;
        @(negedge clk);
        chk("reset-cycle rvalid", 32'(rvalid), 0);
        chk("reset swap_pending", 32'(swap_pending), 0);
        chk("reset err", 32'(err), 0);
        chk("reset rd", rd, 0);
        re = 0; reset_n = 1;
        front_m = 0; pend_m = 0; frame_m = 0; last_rd_m = 0;
        op(0, 0, 0, 0, 0, 0);
        check_tex();
        op(0, 1, 0, 32'h8000, 0, 0);
        repeat (3) op(0, 0, 0, 0, 0, 1);
        op(0, 1, 0, 32'h8004, 0, 0);
        op(0, 0, 0, 0, 0, 0);
        #1;
        chk("scoreboard drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_mapped.md
# dmem_mapped

Memory-mapped data-memory subsystem for the single-cycle ARM core. It replaces the write-only split RAM/VRAM data path with a decoded address map: byte-lane RAM, double-buffered readable VRAM, and a small IO register page. A swap FSM exchanges the front and back VRAM banks only at vertical sync, so the VGA pipeline never shows a half-drawn frame. It sits between the core's data port and the VGA texture fetch (`tex_o`).

## Interface
- `DATA_W`, 32: data word width; byte lanes = DATA_W/8.
- `RAM_WORDS`, 4096: RAM depth in words; must be ≤ 4096.
- `VRAM_WORDS`, `VGA_SCREEN_SIZE`: words per VRAM bank.
- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `we` in 1: write strobe.
- `re` in 1: read strobe.
- `size` in 1: 0 = word access, 1 = byte access (LDRB/STRB).
- `a` in 32: byte address.
- `wd` in DATA_W: write data; byte writes take `wd[7:0]`.
- `rd` out DATA_W: registered read data.
- `rvalid` out 1: `rd` valid this cycle.
- `err` out 1: one-cycle pulse flagging an illegal access.
- `vsync` in 1: one-cycle frame-boundary pulse from the VGA timing block.
- `swap_pending` out 1: a swap has been requested and is waiting for `vsync`.
- `tex_o` out DATA_W × VRAM_WORDS: unpacked array holding the front bank contents.

## Operation
- Decode:
  - region = `a[15:14]`; word index = `a[13:2]`; byte lane = `a[1:0]`.
  - 00: RAM. 01: VRAM back bank (read/write). 10: IO page. 11: unmapped.
- Illegal accesses raise `err`, drop the write, and return 0 on `rd`. They are:
  - word access with `a[1:0]` ≠ 0;
  - unmapped region;
  - RAM index ≥ RAM_WORDS;
  - VRAM index ≥ VRAM_WORDS;
  - IO offset not listed below.
- Byte write: updates only lane `a[1:0]`. Byte read: lane returned zero-extended.
- IO page:
  - 0x8000 CTRL. Write bit0 = 1 requests a swap. Read returns {30'b0, front, swap_pending}.
  - 0x8004 FRAME_CNT. Read-only; writes are ignored without `err`. Increments on every `vsync` and wraps at 2^32.
  - IO byte accesses set `err`.
- Swap FSM, states IDLE and PENDING:
  - IDLE → PENDING on a CTRL write with bit0 = 1.
  - PENDING → IDLE on `vsync`; `front` toggles on the same edge.
  - A request while PENDING has no further effect.
  - `vsync` in the same cycle as a request made from IDLE does not swap; the swap happens at the next `vsync`.
- Back bank = `!front`. CPU VRAM reads and writes always target the back bank. `tex_o` always shows the front bank.
- A VRAM write in the cycle `front` toggles lands in the pre-toggle back bank, which becomes the front bank.
- `we` and `re` together: both are performed. `rd` returns the pre-write value (read-before-write).

## Timing
- Writes commit on the clock edge where `we` = 1.
- Read latency is 1 cycle: `re` at cycle N gives `rvalid` = 1 and `rd` at N+1. Back-to-back reads sustain 1 per cycle.
- `rvalid` = 0 in cycles without a preceding `re`. `rd` holds its last value in those cycles.
- `err` is asserted at N+1 for an illegal access at N (read or write).
- `swap_pending` and `tex_o` bank selection change on the edge after the triggering event.
- Reset (`reset_n` = 0 at an edge) sets:
  - `rd` = 0, `rvalid` = 0, `err` = 0;
  - `swap_pending` = 0, FSM = IDLE;
  - `front` = 0, FRAME_CNT = 0.
- RAM and VRAM contents are not reset.
- Reset while PENDING cancels the swap, with no toggle.
- A read issued in the reset cycle returns no `rvalid`.

## Structure
- `arm_const` package holds:
  - `VGA_SCREEN_SIZE`;
  - region enum `dmem_region_t` (RAM, VRAM, IO, NONE);
  - IO offsets `IO_CTRL` and `IO_FRAME_CNT`;
  - swap state enum `swap_state_t`.
- Sub-module `vram_dbuf` contains:
  - two VRAM_WORDS banks;
  - `front` select;
  - back-bank byte-lane write and registered read;
  - the `tex_o` front-bank mux.
- RAM is an inline byte-lane array. The top level holds the decoder, IO registers, swap FSM and read-data mux.

## Test plan
- Word write 0xDEADBEEF to 0x0010, then `re` at 0x0010 → `rvalid` and `rd` = 0xDEADBEEF exactly 1 cycle later. Byte read at 0x0011 → 0x000000BE.
- STRB 0x55 to 0x0012 over 0xDEADBEEF → word reads 0xDE55BEEF. Word write to 0x0013 → `err` pulse, memory unchanged.
- Write 0x12345678 to VRAM 0x4000 and read it back → 0x12345678, with `tex_o[0]` unchanged. CTRL write 1 → `swap_pending` = 1. `vsync` → `tex_o[0]` = 0x12345678, `swap_pending` = 0, CTRL reads 0x2.
- CTRL write 1 and `vsync` in the same cycle → no toggle, `swap_pending` = 1. Next `vsync` toggles. Three `vsync` pulses → FRAME_CNT reads 3.
- Access to 0xC000 and to VRAM index VRAM_WORDS → `err`, `rd` = 0, no state change.
- `reset_n` low while PENDING → `swap_pending` = 0, front = 0, FRAME_CNT = 0, `rvalid` = 0 next cycle.
